fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/core_pkg.sv | 21 ++
 rtl/fetch_skid.sv | 34 +++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the instruction-fetch front end: reset vector,
// fetch FSM encoding, PC stride and the {pc,instr} packet carried by the skid.
package core_pkg;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched {pc,instr} word while the output
// register is blocked. Only the full flag is reset; the payload is qualified by it.
module fetch_skid
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       unload,
  input  logic       clear,
  input  fetch_pkt_t pkt,
  output fetch_pkt_t head,
  output logic       full
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load && !clear) begin
      head <= pkt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a registered
// {pc,instr} output stage with a one-entry skid, and redirect handling.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcSrc,
  input  logic [31:0] branchTarget,
  input  logic        stall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instrValid
);

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_n;
  logic [31:0] drop_addr;
  logic        can_load;
  logic        out_load;
  logic        out_clear;
  fetch_pkt_t  out_pkt;
  fetch_pkt_t  skid_head;
  logic        skid_load;
  logic        skid_unload;
  logic        skid_clear;
  logic        skid_full;

  assign can_load = !instrValid || !stall;

  // Gating with rst keeps the request low during reset while the FSM rests in REQ.
  assign imemReq  = rst && (state != ST_HOLD);
  assign imemAddr = (state == ST_DROP) ? drop_addr : fetch_pc;

  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    out_load    = 1'b0;
    out_clear   = 1'b0;
    out_pkt     = '{pc: fetch_pc, instr: imemData};
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (pcSrc) begin
      fetch_pc_n = word_align(branchTarget);
      out_clear  = 1'b1;
      skid_clear = 1'b1;
      // Only an unanswered request has to be waited out in DROP.
      if ((state == ST_HOLD) || imemValid) begin
        state_n = ST_REQ;
      end else begin
        state_n = ST_DROP;
      end
    end else begin
      case (state)
        ST_REQ: begin
          if (imemValid) begin
            fetch_pc_n = fetch_pc + PC_STEP;
            if (can_load) begin
              out_load = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_n   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            out_load    = 1'b1;
            out_pkt     = skid_head;
            skid_unload = 1'b1;
            state_n     = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imemValid) begin
            state_n = ST_REQ;
          end
        end
        default: state_n = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_REQ;
      fetch_pc   <= word_align(RESET_VEC);
      pc         <= '0;
      instr      <= '0;
      instrValid <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if (out_clear) begin
        pc         <= '0;
        instr      <= '0;
        instrValid <= 1'b0;
      end else if (out_load) begin
        pc         <= out_pkt.pc;
        instr      <= out_pkt.instr;
        instrValid <= 1'b1;
      end else if (!stall) begin
        instrValid <= 1'b0;
      end
    end
  end

  // Address of the request being abandoned; held on imemAddr until it is answered.
  always_ff @(posedge clk) begin
    if (pcSrc && (state == ST_REQ) && !imemValid) begin
      drop_addr <= fetch_pc;
    end
  end

  fetch_skid u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .pkt    ('{pc: fetch_pc, instr: imemData}),
    .head   (skid_head),
    .full   (skid_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized stall,
// redirect and memory latency, checked against an in-order fetch stream model.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcSrc = 1'b0;
  logic [31:0] branchTarget = '0;
  logic        stall = 1'b0;
  logic        imemValid = 1'b0;
  logic [31:0] imemData = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instrValid;

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          mem_cnt = 0;
  int          n_xfer = 0;
  bit          rand_lat = 1'b0;
  logic [31:0] exp_pc = RV;

  fetch_unit #(.RESET_VEC(RV)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcSrc        (pcSrc),
    .branchTarget (branchTarget),
    .stall        (stall),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemValid    (imemValid),
    .imemData     (imemData),
    .pc           (pc),
    .instr        (instr),
    .instrValid   (instrValid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // One clock: score any transfer, apply redirects to the stream model,
  // check protocol after the edge, then advance the memory model.
  task automatic tick();
    logic        p_req, p_val, p_src, p_iv, p_stall, p_rst;
    logic [31:0] p_addr, p_pc, p_instr, p_tgt;
    #1;
    p_req = imemReq; p_val = imemValid; p_src = pcSrc; p_iv = instrValid;
    p_stall = stall; p_rst = rst; p_addr = imemAddr; p_pc = pc;
    p_instr = instr; p_tgt = branchTarget;
    if (p_rst && p_iv && !p_stall) begin
      chk("xfer_pc", p_pc, exp_pc);
      chk("xfer_instr", p_instr, mem_word(p_pc));
      exp_pc = exp_pc + 32'd4;
      n_xfer++;
    end
    if (p_rst && p_src) exp_pc = {p_tgt[31:2], 2'b00};
    @(posedge clk);
    #1;
    if (rst && p_rst) begin
      if (p_req && !p_val) begin
        chk1("req_stable", imemReq, 1'b1);
        chk("addr_stable", imemAddr, p_addr);
      end
      if (p_src) chk1("redirect_clears", instrValid, 1'b0);
    end
    if (!rst) begin
      imemValid = 1'b0;
      mem_cnt = 0;
    end else if (p_val) begin
      imemValid = 1'b0;
      mem_cnt = 0;
    end else if (p_req) begin
      mem_cnt++;
      if (mem_cnt >= lat) begin
        imemValid = 1'b1;
        imemData = mem_word(p_addr);
        if (rand_lat) lat = $urandom_range(1, 3);
      end
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk1("rst_valid", instrValid, 1'b0);
    chk1("rst_req", imemReq, 1'b0);
    chk("rst_addr", imemAddr, RV);
    pcSrc = 1'b0;
    stall = 1'b0;
    repeat (2) tick();
    chk1("rst_skid_empty", dut.skid_full, 1'b0);
    exp_pc = RV;
    rst = 1'b1;
    #1;
    chk1("post_rst_req", imemReq, 1'b1);
    chk("post_rst_addr", imemAddr, RV);
  endtask

  task automatic wait_valid(input int maxc);
    for (int w = 0; w < maxc && !instrValid; w++) tick();
    chk1("wait_instr_valid", instrValid, 1'b1);
  endtask

  initial begin
    do_reset();

    // Latency-1 stream, no stall: response cycle N presents at N+1.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 8 && !imemValid; w++) tick();
      chk1("resp_seen", imemValid, 1'b1);
      chk("resp_addr", imemAddr, 32'(k * 4));
      tick();
      chk1("lat_valid", instrValid, 1'b1);
      chk("seq_pc", pc, 32'(k * 4));
      chk("seq_instr", instr, mem_word(32'(k * 4)));
    end
    chk("next_addr", imemAddr, 32'h8);

    // Stall for three cycles while the 0x8 response arrives.
    stall = 1'b1;
    tick();
    tick();
    chk("hold_pc", pc, 32'h4);
    chk1("hold_valid", instrValid, 1'b1);
    chk1("hold_req", imemReq, 1'b0);
    chk1("hold_skid_full", dut.skid_full, 1'b1);
    tick();
    chk("hold_pc2", pc, 32'h4);
    chk1("hold_req2", imemReq, 1'b0);
    stall = 1'b0;
    tick();
    chk("unskid_pc", pc, 32'h8);
    chk("unskid_instr", instr, mem_word(32'h8));
    chk1("unskid_valid", instrValid, 1'b1);
    chk1("unskid_req", imemReq, 1'b1);
    chk("unskid_addr", imemAddr, 32'hC);

    // Redirect while 0xC is outstanding.
    pcSrc = 1'b1;
    branchTarget = 32'h100;
    tick();
    pcSrc = 1'b0;
    chk1("drop_valid", instrValid, 1'b0);
    chk1("drop_req", imemReq, 1'b1);
    chk("drop_addr", imemAddr, 32'hC);
    tick();
    chk("redir_addr", imemAddr, 32'h100);
    chk1("redir_valid", instrValid, 1'b0);
    wait_valid(10);
    chk("redir_pc", pc, 32'h100);
    chk("redir_instr", instr, mem_word(32'h100));

    // Redirect coincident with a response while stalled.
    stall = 1'b1;
    tick();
    chk1("coinc_resp", imemValid, 1'b1);
    pcSrc = 1'b1;
    branchTarget = 32'h200;
    tick();
    pcSrc = 1'b0;
    chk1("coinc_valid", instrValid, 1'b0);
    chk1("coinc_skid_empty", dut.skid_full, 1'b0);
    chk("coinc_addr", imemAddr, 32'h200);
    wait_valid(10);
    chk("coinc_pc", pc, 32'h200);
    chk("coinc_instr", instr, mem_word(32'h200));

    // Unaligned target near the top of the address space, then wrap.
    stall = 1'b0;
    pcSrc = 1'b1;
    branchTarget = 32'hFFFF_FFFE;
    tick();
    pcSrc = 1'b0;
    tick();
    chk("wrap_addr", imemAddr, 32'hFFFF_FFFC);
    wait_valid(10);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", imemAddr, 32'h0);

    // Reset asserted in HOLD with the skid full.
    stall = 1'b1;
    for (int w = 0; w < 8 && imemReq; w++) tick();
    chk1("pre_rst_hold_req", imemReq, 1'b0);
    chk1("pre_rst_skid_full", dut.skid_full, 1'b1);
    do_reset();

    // Randomized stall, redirects and memory latency.
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 99) < 35);
      pcSrc = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 3) == 0) branchTarget = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else branchTarget = $urandom & 32'h0000_0FFF;
      tick();
    end
    pcSrc = 1'b0;
    stall = 1'b0;
    chk1("random_progress", n_xfer > 150, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
